// File: rtl/ex_shift_arb_pkg.sv
// Shared definitions for the EX-stage shifter arbiter: bus widths, shift
// type codes, requester IDs and the request payload struct.
package ex_shift_arb_pkg;

  localparam int unsigned SHIFT_TYPE_BUS = 3;
  localparam int unsigned IMM_SHIFT_BUS  = 6;
  localparam int unsigned DATA_BUS       = 64;
  localparam int unsigned HALF_BUS       = DATA_BUS / 2;

  localparam logic [SHIFT_TYPE_BUS-1:0] SHIFT_SLL  = 3'b011;
  localparam logic [SHIFT_TYPE_BUS-1:0] SHIFT_SRA  = 3'b100;
  localparam logic [SHIFT_TYPE_BUS-1:0] SHIFT_SRL  = 3'b101;
  localparam logic [SHIFT_TYPE_BUS-1:0] SHIFT_SRAW = 3'b110;
  localparam logic [SHIFT_TYPE_BUS-1:0] SHIFT_SRLW = 3'b111;

  localparam logic SHIFT_ID_PIPE = 1'b0;
  localparam logic SHIFT_ID_MDU  = 1'b1;

  // One shift request as presented by either requester.
  typedef struct packed {
    logic [SHIFT_TYPE_BUS-1:0] op;
    logic [DATA_BUS-1:0]       src;
    logic [IMM_SHIFT_BUS-1:0]  amt;
  } shift_req_t;

  // Word ops occupy the two codes with both upper bits set.
  function automatic logic is_word_op(input logic [SHIFT_TYPE_BUS-1:0] op);
    return (op == SHIFT_SRAW) || (op == SHIFT_SRLW);
  endfunction

endpackage

// File: rtl/ex_shifter.sv
// Combinational 64-bit barrel shifter used by the EX stage.
// Ports: shift_num_src selects imm_shift (1) or rs2_data (0) as the amount;
// inst_shift enables the result; shift_type/src are the operation and
// operand; result_c is the raw result (word ops return the 32-bit result
// zero-extended, sign extension is left to the consumer).
module ex_shifter
  import ex_shift_arb_pkg::*;
(
  input  logic                      shift_num_src,
  input  logic [IMM_SHIFT_BUS-1:0]  imm_shift,
  input  logic [IMM_SHIFT_BUS-1:0]  rs2_data,
  input  logic                      inst_shift,
  input  logic [SHIFT_TYPE_BUS-1:0] shift_type,
  input  logic [DATA_BUS-1:0]       src,
  output logic [DATA_BUS-1:0]       result_c
);

  logic [IMM_SHIFT_BUS-1:0] amt;
  logic [HALF_BUS-1:0]      word;

  // Decode and shift; word ops only honour the low five amount bits.
  always_comb begin
    amt      = shift_num_src ? imm_shift : rs2_data;
    word     = src[HALF_BUS-1:0];
    result_c = '0;
    if (inst_shift) begin
      case (shift_type)
        SHIFT_SLL:  result_c = src << amt;
        SHIFT_SRA:  result_c = $unsigned($signed(src) >>> amt);
        SHIFT_SRL:  result_c = src >> amt;
        SHIFT_SRAW: result_c = {HALF_BUS'(0), $unsigned($signed(word) >>> amt[4:0])};
        SHIFT_SRLW: result_c = {HALF_BUS'(0), word >> amt[4:0]};
        default:    result_c = '0;
      endcase
    end
  end

endmodule

// File: rtl/ex_shift_arb.sv
// Arbitrates the shared EX barrel shifter between the pipeline (port 0) and
// the MDU (port 1). Pipeline has priority; after STARVE_LIMIT consecutive
// pipeline grants with the MDU waiting, the MDU is forced through. Results
// land in a one-entry registered response slot (valid/ready).
// Ports: clk, rst_n, flush (kills pipeline traffic); p0_*/p1_* request
// valid/ready/type/src/amt; rsp_valid/rsp_ready/rsp_id/rsp_data response.
module ex_shift_arb
  import ex_shift_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 3,
  parameter bit          SEXT_WORD    = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      p0_valid,
  output logic                      p0_ready,
  input  logic [SHIFT_TYPE_BUS-1:0] p0_type,
  input  logic [DATA_BUS-1:0]       p0_src,
  input  logic [IMM_SHIFT_BUS-1:0]  p0_amt,
  input  logic                      p1_valid,
  output logic                      p1_ready,
  input  logic [SHIFT_TYPE_BUS-1:0] p1_type,
  input  logic [DATA_BUS-1:0]       p1_src,
  input  logic [IMM_SHIFT_BUS-1:0]  p1_amt,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic                      rsp_id,
  output logic [DATA_BUS-1:0]       rsp_data
);

  localparam int unsigned CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0]    starve_cnt, starve_cnt_d;
  logic                rsp_valid_d, rsp_id_d;
  logic [DATA_BUS-1:0] rsp_data_d;

  shift_req_t          p0_req, p1_req, win_req;
  logic                p0_eff, grant_p1, grant_p0, slot_free, accept;
  logic [DATA_BUS-1:0] raw_c, shift_res;

  // Grant and slot availability; a flush frees a slot held by the pipeline.
  always_comb begin
    p0_req    = '{op: p0_type, src: p0_src, amt: p0_amt};
    p1_req    = '{op: p1_type, src: p1_src, amt: p1_amt};
    p0_eff    = p0_valid & ~flush;
    grant_p1  = p1_valid & (~p0_eff | (starve_cnt == CNT_MAX));
    grant_p0  = ~grant_p1 & p0_eff;
    slot_free = ~rsp_valid | rsp_ready | (flush & (rsp_id == SHIFT_ID_PIPE));
    // Nothing is accepted while reset is asserted.
    p0_ready  = rst_n & slot_free & grant_p0;
    p1_ready  = rst_n & slot_free & grant_p1;
    accept    = p0_ready | p1_ready;
    win_req   = grant_p1 ? p1_req : p0_req;
  end

  ex_shifter u_shifter (
    .shift_num_src (1'b1),
    .imm_shift     (win_req.amt),
    .rs2_data      ('0),
    .inst_shift    (1'b1),
    .shift_type    (win_req.op),
    .src           (win_req.src),
    .result_c      (raw_c)
  );

  // Optional RV64 word sign extension so consumers get final values.
  always_comb begin
    shift_res = raw_c;
    if (SEXT_WORD && is_word_op(win_req.op)) begin
      shift_res = {{HALF_BUS{raw_c[HALF_BUS-1]}}, raw_c[HALF_BUS-1:0]};
    end
  end

  // Response slot and starvation counter next-state.
  always_comb begin
    rsp_valid_d  = rsp_valid;
    rsp_id_d     = rsp_id;
    rsp_data_d   = rsp_data;
    starve_cnt_d = starve_cnt;

    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_id_d    = grant_p1 ? SHIFT_ID_MDU : SHIFT_ID_PIPE;
      rsp_data_d  = shift_res;
    end else if (slot_free) begin
      rsp_valid_d = 1'b0;
    end

    if (!p1_valid || p1_ready) begin
      starve_cnt_d = '0;
    end else if (p0_ready && (starve_cnt != CNT_MAX)) begin
      starve_cnt_d = starve_cnt + CNT_W'(1);
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid  <= 1'b0;
      rsp_id     <= SHIFT_ID_PIPE;
      rsp_data   <= '0;
      starve_cnt <= '0;
    end else begin
      rsp_valid  <= rsp_valid_d;
      rsp_id     <= rsp_id_d;
      rsp_data   <= rsp_data_d;
      starve_cnt <= starve_cnt_d;
    end
  end

endmodule

// File: tb/tb_ex_shift_arb.sv
// Directed self-checking bench for ex_shift_arb (STARVE_LIMIT=3, SEXT_WORD=1).
module tb_ex_shift_arb;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        p0_valid, p0_ready;
  logic [2:0]  p0_type;
  logic [63:0] p0_src;
  logic [5:0]  p0_amt;
  logic        p1_valid, p1_ready;
  logic [2:0]  p1_type;
  logic [63:0] p1_src;
  logic [5:0]  p1_amt;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [63:0] rsp_data;

  int checks = 0;
  int errors = 0;

  ex_shift_arb #(.STARVE_LIMIT(3), .SEXT_WORD(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .p0_valid  (p0_valid),
    .p0_ready  (p0_ready),
    .p0_type   (p0_type),
    .p0_src    (p0_src),
    .p0_amt    (p0_amt),
    .p1_valid  (p1_valid),
    .p1_ready  (p1_ready),
    .p1_type   (p1_type),
    .p1_src    (p1_src),
    .p1_amt    (p1_amt),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_p0(input logic v, input logic [2:0] t, input logic [63:0] s, input logic [5:0] a);
    p0_valid = v; p0_type = t; p0_src = s; p0_amt = a;
  endtask

  task automatic set_p1(input logic v, input logic [2:0] t, input logic [63:0] s, input logic [5:0] a);
    p1_valid = v; p1_type = t; p1_src = s; p1_amt = a;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; rsp_ready = 1'b1;
    set_p0(1'b1, 3'b011, 64'h1, 6'd0);
    set_p1(1'b0, 3'b011, 64'h0, 6'd0);
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", rsp_valid); end
    checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL reset_id got %b exp 0", rsp_id); end
    checks++; if (rsp_data !== 64'h0) begin errors++; $display("FAIL reset_data got %h exp 0", rsp_data); end
    checks++; if (p0_ready !== 1'b0) begin errors++; $display("FAIL reset_p0_ready got %b exp 0", p0_ready); end
    step(); step();
    set_p0(1'b0, 3'b011, 64'h0, 6'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_port0();
    rsp_ready = 1'b1;
    set_p0(1'b1, 3'b101, 64'h8000_0000_0000_0000, 6'd4);
    #1;
    checks++; if (p0_ready !== 1'b1) begin errors++; $display("FAIL p0_ready_empty got %b exp 1", p0_ready); end
    step();
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL srl_valid got %b exp 1", rsp_valid); end
    checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL srl_id got %b exp 0", rsp_id); end
    checks++; if (rsp_data !== 64'h0800_0000_0000_0000) begin errors++; $display("FAIL srl_data got %h exp 0800000000000000", rsp_data); end
    set_p0(1'b1, 3'b100, 64'h8000_0000_0000_0000, 6'd4);
    step();
    checks++; if (rsp_data !== 64'hF800_0000_0000_0000) begin errors++; $display("FAIL sra_data got %h exp f800000000000000", rsp_data); end
    set_p0(1'b1, 3'b011, 64'h1, 6'd63);
    step();
    checks++; if (rsp_data !== 64'h8000_0000_0000_0000) begin errors++; $display("FAIL sll63_data got %h exp 8000000000000000", rsp_data); end
    set_p0(1'b0, 3'b011, 64'h0, 6'd0);
    step();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL idle_valid got %b exp 0", rsp_valid); end
  endtask

  task automatic test_word();
    rsp_ready = 1'b1;
    set_p0(1'b1, 3'b111, 64'hFFFF_FFFF_8000_0000, 6'd4);
    step();
    checks++; if (rsp_data !== 64'h0000_0000_0800_0000) begin errors++; $display("FAIL srlw_data got %h exp 0000000008000000", rsp_data); end
    set_p0(1'b1, 3'b110, 64'hFFFF_FFFF_8000_0000, 6'd4);
    step();
    checks++; if (rsp_data !== 64'hFFFF_FFFF_F800_0000) begin errors++; $display("FAIL sraw_data got %h exp fffffffff8000000", rsp_data); end
    set_p0(1'b1, 3'b111, 64'hFFFF_FFFF_8000_0000, 6'd36);
    step();
    checks++; if (rsp_data !== 64'h0000_0000_0800_0000) begin errors++; $display("FAIL srlw36_data got %h exp 0000000008000000", rsp_data); end
    // Amount 0 on a word op still sign-extends bit 31.
    set_p0(1'b1, 3'b111, 64'h0000_0000_8000_0001, 6'd0);
    step();
    checks++; if (rsp_data !== 64'hFFFF_FFFF_8000_0001) begin errors++; $display("FAIL srlw0_data got %h exp ffffffff80000001", rsp_data); end
    set_p0(1'b1, 3'b000, 64'h1234_5678_9ABC_DEF0, 6'd3);
    step();
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL badtype_valid got %b exp 1", rsp_valid); end
    checks++; if (rsp_data !== 64'h0) begin errors++; $display("FAIL badtype_data got %h exp 0", rsp_data); end
    set_p0(1'b0, 3'b011, 64'h0, 6'd0);
    step();
  endtask

  task automatic test_starve();
    logic [7:0] exp_grant;
    exp_grant = 8'b1000_1000; // bit i = expected grant on cycle i
    rsp_ready = 1'b1;
    set_p0(1'b1, 3'b011, 64'h10, 6'd0);
    set_p1(1'b1, 3'b011, 64'h20, 6'd0);
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++; if (p1_ready !== exp_grant[i]) begin errors++; $display("FAIL starve_p1_ready[%0d] got %b exp %b", i, p1_ready, exp_grant[i]); end
      checks++; if (p0_ready !== !exp_grant[i]) begin errors++; $display("FAIL starve_p0_ready[%0d] got %b exp %b", i, p0_ready, !exp_grant[i]); end
      step();
      checks++; if (rsp_id !== exp_grant[i]) begin errors++; $display("FAIL starve_id[%0d] got %b exp %b", i, rsp_id, exp_grant[i]); end
      checks++; if (rsp_data !== (exp_grant[i] ? 64'h20 : 64'h10)) begin errors++; $display("FAIL starve_data[%0d] got %h", i, rsp_data); end
    end
    set_p0(1'b0, 3'b011, 64'h0, 6'd0);
    set_p1(1'b0, 3'b011, 64'h0, 6'd0);
    step();
  endtask

  task automatic test_back_to_back();
    rsp_ready = 1'b1;
    set_p0(1'b1, 3'b011, 64'h1234, 6'd0);
    step();
    rsp_ready = 1'b0;
    set_p0(1'b1, 3'b011, 64'h55, 6'd0);
    set_p1(1'b1, 3'b011, 64'h66, 6'd0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (p0_ready !== 1'b0 || p1_ready !== 1'b0) begin errors++; $display("FAIL hold_ready[%0d] got %b%b exp 00", i, p0_ready, p1_ready); end
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== 64'h1234) begin errors++; $display("FAIL hold_rsp[%0d] got v%b id%b %h exp v1 id0 1234", i, rsp_valid, rsp_id, rsp_data); end
      step();
    end
    rsp_ready = 1'b1;
    #1;
    checks++; if (p0_ready !== 1'b1) begin errors++; $display("FAIL drain_p0_ready got %b exp 1", p0_ready); end
    step();
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== 64'h55) begin errors++; $display("FAIL nobubble got v%b id%b %h exp v1 id0 55", rsp_valid, rsp_id, rsp_data); end
    set_p0(1'b0, 3'b011, 64'h0, 6'd0);
    set_p1(1'b0, 3'b011, 64'h0, 6'd0);
    step();
  endtask

  task automatic test_flush();
    rsp_ready = 1'b0;
    set_p0(1'b1, 3'b011, 64'h77, 6'd0);
    step();
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 64'h77) begin errors++; $display("FAIL flush_setup got v%b %h exp v1 77", rsp_valid, rsp_data); end
    flush = 1'b1;
    set_p1(1'b1, 3'b011, 64'h3, 6'd1);
    #1;
    checks++; if (p0_ready !== 1'b0 || p1_ready !== 1'b1) begin errors++; $display("FAIL flush_grant got p0 %b p1 %b exp p0 0 p1 1", p0_ready, p1_ready); end
    step();
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_data !== 64'h6) begin errors++; $display("FAIL flush_p1 got v%b id%b %h exp v1 id1 6", rsp_valid, rsp_id, rsp_data); end
    set_p1(1'b1, 3'b011, 64'h9, 6'd0);
    #1;
    checks++; if (p1_ready !== 1'b0) begin errors++; $display("FAIL flush_p1hold_ready got %b exp 0", p1_ready); end
    step();
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_data !== 64'h6) begin errors++; $display("FAIL flush_p1hold got v%b id%b %h exp v1 id1 6", rsp_valid, rsp_id, rsp_data); end
    flush = 1'b0;
    set_p1(1'b0, 3'b011, 64'h0, 6'd0);
    rsp_ready = 1'b1;
    set_p0(1'b1, 3'b011, 64'h44, 6'd0);
    step();
    rsp_ready = 1'b0;
    set_p0(1'b0, 3'b011, 64'h0, 6'd0);
    flush = 1'b1;
    step();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL flush_kill got %b exp 0", rsp_valid); end
    flush = 1'b0;
    rsp_ready = 1'b1;
    step();
  endtask

  task automatic test_reset_mid();
    rsp_ready = 1'b1;
    set_p0(1'b1, 3'b011, 64'hA, 6'd0);
    set_p1(1'b1, 3'b011, 64'hB, 6'd0);
    step(); step(); // two pipeline grants with the MDU waiting
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 64'hA) begin errors++; $display("FAIL rmid_setup got v%b %h exp v1 a", rsp_valid, rsp_data); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b0 || rsp_id !== 1'b0 || rsp_data !== 64'h0) begin errors++; $display("FAIL rmid_async got v%b id%b %h exp v0 id0 0", rsp_valid, rsp_id, rsp_data); end
    checks++; if (p0_ready !== 1'b0 || p1_ready !== 1'b0) begin errors++; $display("FAIL rmid_ready got %b%b exp 00", p0_ready, p1_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (p0_ready !== 1'b1 || p1_ready !== 1'b0) begin errors++; $display("FAIL rmid_prio got p0 %b p1 %b exp p0 1 p1 0", p0_ready, p1_ready); end
    step();
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== 64'hA) begin errors++; $display("FAIL rmid_first got v%b id%b %h exp v1 id0 a", rsp_valid, rsp_id, rsp_data); end
    set_p0(1'b0, 3'b011, 64'h0, 6'd0);
    set_p1(1'b0, 3'b011, 64'h0, 6'd0);
    step();
  endtask

  initial begin
    test_reset();
    test_port0();
    test_word();
    test_starve();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_shift_arb.md
Name: ex_shift_arb

Overview:
- Shares the single EX-stage 64-bit barrel shifter between two requesters: the EX pipeline (port 0, shift instructions) and the iterative multiply/divide unit (port 1, normalisation shifts).
- Fixed priority to the pipeline, with a starvation guard for the MDU.
- Result is registered into a one-entry response slot with valid/ready handshake; throughput 1 op/cycle, latency 1 cycle.
- Word-op results are optionally sign-extended here so both consumers receive final RV64 values.

Parameters:
- STARVE_LIMIT, 3: max consecutive port-0 grants while port 1 is waiting; next grant is forced to port 1.
- SEXT_WORD, 1: 1 = sign-extend bit 31 of the result for word types (110, 111); 0 = raw shifter output.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  pipeline flush; kills port-0 traffic
- p0_valid  in  1  pipeline request valid
- p0_ready  out  1  pipeline request accepted
- p0_type  in  3  shift type (SHIFT_TYPE_BUS)
- p0_src  in  64  operand (DATA_BUS)
- p0_amt  in  6  shift amount (IMM_SHIFT_BUS)
- p1_valid  in  1  MDU request valid
- p1_ready  out  1  MDU request accepted
- p1_type  in  3  shift type
- p1_src  in  64  operand
- p1_amt  in  6  shift amount
- rsp_valid  out  1  response slot full
- rsp_ready  in  1  consumer takes response
- rsp_id  out  1  0 = pipeline, 1 = MDU
- rsp_data  out  64  shift result

Behaviour:
- Type encoding:
  - 011 SLL
  - 100 SRA
  - 101 SRL
  - 110 SRAW
  - 111 SRLW
  - Any other code: accepted, result 64'h0.
  - Word ops use amt[4:0] only.
- Reset: rsp_valid=0, rsp_id=0, rsp_data=0, starve_cnt=0.
  - Reset asserted mid-operation drops the held response immediately; no request is accepted during reset.
- Slot availability:
  - slot_free = !rsp_valid | rsp_ready.
  - With flush=1, slot_free is also true when the held response has rsp_id==0.
- Grant (combinational):
  - p0_eff = p0_valid & !flush.
  - Port 1 wins if p1_valid and (!p0_eff or starve_cnt==STARVE_LIMIT); otherwise port 0 wins if p0_eff.
  - pK_ready = slot_free & (grant==K).
  - pK_ready is high only when pK_valid is high; the MDU sees p1_ready=1 only on its winning cycle.
- Transfer: on a grant with slot_free, the winner's operands drive the shifter. On the next clk edge the slot loads rsp_data (post-SEXT_WORD), rsp_id=K, rsp_valid=1.
- Response hold: rsp_valid/rsp_id/rsp_data are held stable while rsp_valid & !rsp_ready. Back-to-back accept-and-drain in the same cycle is allowed.
- No accept: if there is no grant while rsp_ready (or slot empty), the next rsp_valid=0.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) on each accepted port-0 transfer while p1_valid=1.
  - Clears on any accepted port-1 transfer, or whenever p1_valid=0.
- Flush:
  - Masks port 0 in the same cycle.
  - Clears a held port-0 response (rsp_valid falls next edge unless a port-1 op is loaded).
  - Never affects a port-1 response or request.
- Simultaneous flush and rsp_ready on a port-0 response: the response is treated as drained; there is no double effect.
- Shifter semantics:
  - SRLW zero-fills from bit 31 when amt≠0.
  - SRA/SRAW replicate the sign bit.
  - Amount 0 returns the source, SEXT_WORD-extended for word types.

Decomposition:
- Shared defines file holds: SHIFT_TYPE_BUS, IMM_SHIFT_BUS, DATA_BUS, the five type codes as named constants, and requester-ID constants (SHIFT_ID_PIPE=0, SHIFT_ID_MDU=1).
- One sub-module, the existing shifter instance (ex_shifter):
  - shift_num_src tied to 1.
  - imm_shift driven by the granted amt.
  - rs2_data tied to 0.
  - inst_shift=1.
- Arbitration, starvation counter and response slot stay in ex_shift_arb.

Test Plan:
- Port 0 only, SRL src=64'h8000_0000_0000_0000 amt=4 -> next cycle rsp_valid=1, rsp_id=0, rsp_data=64'h0800_0000_0000_0000. Then SRA same operands -> 64'hF800_0000_0000_0000. Then SLL src=1 amt=63 -> 64'h8000_0000_0000_0000.
- Word ops, src=64'hFFFF_FFFF_8000_0000 amt=4: SRLW -> 64'h0000_0000_0800_0000; SRAW -> 64'hFFFF_FFFF_F800_0000. Amount 36 on SRLW behaves as 4.
- Both ports valid every cycle, rsp_ready=1, STARVE_LIMIT=3 -> grant sequence 0,0,0,1,0,0,0,1; rsp_id follows it one cycle later; p1_ready high only on its slots.
- rsp_ready=0 for 3 cycles with response 0x1234 held -> rsp_data/rsp_id stable, p0_ready=p1_ready=0. When rsp_ready rises, same-cycle accept yields a new response next cycle with no bubble.
- Held port-0 response with rsp_ready=0, assert flush with p1_valid=1 (SLL src=3 amt=1) -> next cycle rsp_id=1, rsp_data=6. Held port-1 response under flush is unchanged.
- Assert rst_n=0 while rsp_valid=1 and starve_cnt=2 -> rsp_valid/rsp_data/rsp_id drop asynchronously to 0. After release, first grant obeys plain port-0 priority.
